// File: rtl/twiddle_mult_seq_if.sv
// Stream and twiddle-LUT signals of twiddle_mult_seq.
// The master modport is the multiplier's view.
// The slave modport is the view of the surrounding logic: the sample source, the sink and the LUT.
interface twiddle_mult_seq_if #(
    parameter int DW = 16,
    parameter int KW = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [2*DW-1:0]   in_data;
    logic              in_last;
    logic [KW-1:0]     k_out;
    logic [2*DW-1:0]   w_in;
    logic              out_valid;
    logic              out_ready;
    logic [2*DW-1:0]   out_data;
    logic              out_last;
    logic              frame_err;

    modport master (
        input  in_valid, in_data, in_last, w_in, out_ready,
        output in_ready, k_out, out_valid, out_data, out_last, frame_err
    );

    modport slave (
        output in_valid, in_data, in_last, w_in, out_ready,
        input  in_ready, k_out, out_valid, out_data, out_last, frame_err
    );
endinterface

// File: rtl/twiddle_mult_seq.sv
// Streaming complex multiplier that requests a twiddle factor per sample.
// The twiddle index is the sample counter modulo the LUT size.
// Each sample is multiplied by W, or by conj(W) when INVERSE is set.
// The pipeline has three stages: capture, products, then sum/round/saturate.
// All three stages share one enable, so backpressure stalls the whole pipe.
module twiddle_mult_seq #(
    parameter int DW      = 16,
    parameter int FRAC    = 8,
    parameter int KW      = 3,
    parameter int NPTS    = 16,
    parameter int INVERSE = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    twiddle_mult_seq_if.master bus
);
    localparam int CW = (NPTS > 1) ? $clog2(NPTS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NPTS - 1);
    localparam logic signed [2*DW:0] ROUND_ADD = (2*DW+1)'(2 ** (FRAC - 1));
    localparam logic signed [2*DW:0] SAT_MAX   = (2*DW+1)'(2 ** (DW - 1) - 1);
    localparam logic signed [2*DW:0] SAT_MIN   = (2*DW+1)'(-(2 ** (DW - 1)));

    // Frame tracking
    logic [CW-1:0]          r_cnt;
    logic                   r_frame_err;

    // Stage 1: captured operands
    logic                   r_v1;
    logic                   r_last1;
    logic signed [DW-1:0]   r_a, r_b, r_c, r_d;

    // Stage 2: partial products
    logic                   r_v2;
    logic                   r_last2;
    logic signed [2*DW-1:0] r_ac, r_bd, r_ad, r_bc;

    // Stage 3: output register
    logic                   r_v3;
    logic                   r_last3;
    logic [2*DW-1:0]        r_out;

    logic                   w_en;
    logic                   w_accept;
    logic                   w_cnt_is_last;
    logic signed [DW-1:0]   w_d_in;
    logic signed [2*DW-1:0] w_a_ext, w_b_ext, w_c_ext, w_d_ext;
    logic signed [2*DW:0]   w_re, w_im;
    logic signed [2*DW:0]   w_re_rnd, w_im_rnd;
    logic signed [2*DW:0]   w_re_shr, w_im_shr;

    // Clamp a wide signed value into the DW-bit output range.
    function automatic logic [DW-1:0] saturate(input logic signed [2*DW:0] v);
        logic [DW-1:0] res;
        if (v > SAT_MAX) begin
            res = SAT_MAX[DW-1:0];
        end else if (v < SAT_MIN) begin
            res = SAT_MIN[DW-1:0];
        end else begin
            res = v[DW-1:0];
        end
        return res;
    endfunction

    // The pipe advances unless a finished sample is waiting for the sink.
    assign w_en          = !r_v3 || bus.out_ready;
    assign w_accept      = bus.in_valid && w_en;
    assign w_cnt_is_last = (r_cnt == LAST_CNT);

    assign bus.in_ready  = w_en;
    assign bus.k_out     = r_cnt[KW-1:0];
    assign bus.out_valid = r_v3;
    assign bus.out_data  = r_out;
    assign bus.out_last  = r_last3;
    assign bus.frame_err = r_frame_err;

    // Conjugating W only flips the sign of the imaginary part of the LUT word.
    assign w_d_in  = (INVERSE != 0) ? -$signed(bus.w_in[DW-1:0]) : $signed(bus.w_in[DW-1:0]);

    // Widen the operands first so that each product keeps its full 2*DW bits.
    assign w_a_ext = (2*DW)'(r_a);
    assign w_b_ext = (2*DW)'(r_b);
    assign w_c_ext = (2*DW)'(r_c);
    assign w_d_ext = (2*DW)'(r_d);

    // Sum at 2*DW+1 bits, add half an LSB, then shift right arithmetically (round half up).
    assign w_re     = (2*DW+1)'(r_ac) - (2*DW+1)'(r_bd);
    assign w_im     = (2*DW+1)'(r_ad) + (2*DW+1)'(r_bc);
    assign w_re_rnd = w_re + ROUND_ADD;
    assign w_im_rnd = w_im + ROUND_ADD;
    assign w_re_shr = w_re_rnd >>> FRAC;
    assign w_im_shr = w_im_rnd >>> FRAC;

    // Sample counter with framing check.
    // An early in_last resyncs the counter to 0.
    // A missing in_last lets the counter wrap normally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_accept && (bus.in_last != w_cnt_is_last);
            if (w_accept) begin
                if (w_cnt_is_last || bus.in_last) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    // Stage 1: capture the sample together with the twiddle returned for this index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_last1 <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_d     <= '0;
        end else if (w_en) begin
            r_v1 <= bus.in_valid;
            if (bus.in_valid) begin
                r_last1 <= w_cnt_is_last || bus.in_last;
                r_a     <= $signed(bus.in_data[2*DW-1:DW]);
                r_b     <= $signed(bus.in_data[DW-1:0]);
                r_c     <= $signed(bus.w_in[2*DW-1:DW]);
                r_d     <= w_d_in;
            end
        end
    end

    // Stage 2: form the four cross products of (a + jb)(c + jd).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v2    <= 1'b0;
            r_last2 <= 1'b0;
            r_ac    <= '0;
            r_bd    <= '0;
            r_ad    <= '0;
            r_bc    <= '0;
        end else if (w_en) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_last2 <= r_last1;
                r_ac    <= w_a_ext * w_c_ext;
                r_bd    <= w_b_ext * w_d_ext;
                r_ad    <= w_a_ext * w_d_ext;
                r_bc    <= w_b_ext * w_c_ext;
            end
        end
    end

    // Stage 3: register the rounded and saturated result.
    // It holds steady while the sink stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v3    <= 1'b0;
            r_last3 <= 1'b0;
            r_out   <= '0;
        end else if (w_en) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_last3 <= r_last2;
                r_out   <= {saturate(w_re_shr), saturate(w_im_shr)};
            end
        end
    end
endmodule
